// File: rtl/dave_pkg.sv
// Shared definitions for the diamond grid: geometry, level count, row type, FSM states.
package dave_pkg;

    localparam int unsigned NUM_LEVELS = 7;
    localparam int unsigned GRID_ROWS  = 15;
    localparam int unsigned GRID_COLS  = 20;
    localparam int unsigned CELL_SHIFT = 5;
    localparam int unsigned COUNT_W    = 9;
    localparam int unsigned POP_W      = 5;

    typedef logic [GRID_COLS-1:0] row_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, CLEAR} diamond_state_t;

    // Number of diamonds in one grid row (0..20).
    function automatic logic [POP_W-1:0] popcount(input row_t r);
        logic [POP_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < GRID_COLS; i++) begin
            n = n + POP_W'(r[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/diamond_level_rom.sv
// Per-level diamond bitmaps, one registered row per cycle; bit 0 is the leftmost column.
module diamond_level_rom
    import dave_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           level,
    input  logic [3:0]           row,
    output logic [GRID_COLS-1:0] data
);

    localparam row_t MAPS [NUM_LEVELS][GRID_ROWS] = '{
        '{20'h00000, 20'h00003, 20'h00000, 20'h00200, 20'h80001, 20'h00F00, 20'h00000, 20'h11111,
          20'h00000, 20'h00030, 20'h00000, 20'h40000, 20'h00000, 20'h0F000, 20'h00000},
        '{20'h00001, 20'h00000, 20'h00010, 20'h00000, 20'h00100, 20'h00000, 20'h01000, 20'h00000,
          20'h10000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000},
        '{20'h00000, 20'h0000F, 20'h00000, 20'h000F0, 20'h00000, 20'h00F00, 20'h00000, 20'h0F000,
          20'h00000, 20'hF0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000},
        '{20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF,
          20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000},
        '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'h003FF, 20'h00000,
          20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000},
        '{20'h55555, 20'h00000, 20'hAAAAA, 20'h00000, 20'h55555, 20'h00000, 20'hAAAAA, 20'h00000,
          20'h55555, 20'h00000, 20'hAAAAA, 20'h00000, 20'h55555, 20'h00000, 20'hAAAAA},
        '{20'h00001, 20'h00002, 20'h00004, 20'h00008, 20'h00010, 20'h00020, 20'h00040, 20'h00080,
          20'h00100, 20'h00200, 20'h00400, 20'h00800, 20'h01000, 20'h02000, 20'h04000}
    };

    // Unknown levels and the row past the last one read back as empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (level < 4'(NUM_LEVELS) && row < 4'(GRID_ROWS)) begin
            data <= MAPS[level[2:0]][row];
        end else begin
            data <= '0;
        end
    end

endmodule

// File: rtl/diamonds_controller.sv
// Live diamond grid: level load from ROM, per-pixel draw lookup, collision collect and level clear.
module diamonds_controller
    import dave_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               level_start,
    input  logic [3:0]         level,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic               collision,
    output logic               drawingRequest,
    output logic               busy,
    output logic [COUNT_W-1:0] diamonds_left,
    output logic               collect_pulse,
    output logic               level_clear
);

    localparam int unsigned CELL_IDX_W = 11 - CELL_SHIFT;

    diamond_state_t         state;
    logic [3:0]             level_q;
    logic [3:0]             load_cnt;
    logic [COUNT_W-1:0]     acc;
    row_t                   grid [GRID_ROWS];
    row_t                   rom_data;
    logic [CELL_IDX_W-1:0]  cell_row;
    logic [CELL_IDX_W-1:0]  cell_col;
    logic                   in_range;
    logic                   cell_hit;
    logic                   unused_pixel_bits;

    diamond_level_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .level (level_q),
        .row   (load_cnt),
        .data  (rom_data)
    );

    // Cell lookup for the current scan position; off-grid cells read as empty.
    assign cell_row          = pixelY[10:CELL_SHIFT];
    assign cell_col          = pixelX[10:CELL_SHIFT];
    assign in_range          = (cell_row < CELL_IDX_W'(GRID_ROWS)) && (cell_col < CELL_IDX_W'(GRID_COLS));
    assign cell_hit          = in_range && grid[cell_row[3:0]][cell_col[4:0]];
    assign unused_pixel_bits = ^{pixelX[CELL_SHIFT-1:0], pixelY[CELL_SHIFT-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            level_q        <= '0;
            load_cnt       <= '0;
            acc            <= '0;
            grid           <= '{default: '0};
            drawingRequest <= 1'b0;
            busy           <= 1'b0;
            diamonds_left  <= '0;
            collect_pulse  <= 1'b0;
            level_clear    <= 1'b0;
        end else begin
            collect_pulse  <= 1'b0;
            level_clear    <= 1'b0;
            drawingRequest <= 1'b0;
            if (level_start) begin
                state         <= LOAD;
                level_q       <= level;
                load_cnt      <= '0;
                acc           <= '0;
                diamonds_left <= '0;
                busy          <= 1'b1;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    // ROM data lags the address by one cycle, so row n is written while n+1 is read.
                    LOAD: begin
                        load_cnt <= load_cnt + 4'd1;
                        if (load_cnt != 4'd0) begin
                            grid[load_cnt - 4'd1] <= rom_data;
                            acc <= acc + COUNT_W'(popcount(rom_data));
                        end
                        if (load_cnt == 4'(GRID_ROWS)) begin
                            diamonds_left <= acc + COUNT_W'(popcount(rom_data));
                            busy          <= 1'b0;
                            state         <= RUN;
                        end
                    end
                    RUN: begin
                        drawingRequest <= cell_hit;
                        if (diamonds_left == '0) begin
                            level_clear <= 1'b1;
                            state       <= CLEAR;
                        end else if (collision && cell_hit) begin
                            grid[cell_row[3:0]][cell_col[4:0]] <= 1'b0;
                            diamonds_left <= diamonds_left - COUNT_W'(1);
                            collect_pulse <= 1'b1;
                        end
                    end
                    CLEAR:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_diamonds_controller.sv
// Directed bench for diamonds_controller: load timing, draw lookup, collect, level clear, abort, reset.
module tb_diamonds_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        level_start;
    logic [3:0]  level;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        collision;
    logic        drawingRequest;
    logic        busy;
    logic [8:0]  diamonds_left;
    logic        collect_pulse;
    logic        level_clear;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        col;
        logic        exp_draw;
        logic        exp_collect;
        int          exp_left;
        string       name;
    } vec_t;

    logic [19:0] map0 [15] = '{20'h00000, 20'h00003, 20'h00000, 20'h00200, 20'h80001,
                               20'h00F00, 20'h00000, 20'h11111, 20'h00000, 20'h00030,
                               20'h00000, 20'h40000, 20'h00000, 20'h0F000, 20'h00000};

    diamonds_controller dut (
        .clk            (clk),
        .reset          (reset),
        .level_start    (level_start),
        .level          (level),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .collision      (collision),
        .drawingRequest (drawingRequest),
        .busy           (busy),
        .diamonds_left  (diamonds_left),
        .collect_pulse  (collect_pulse),
        .level_clear    (level_clear)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_level(input logic [3:0] lv);
        level       = lv;
        level_start = 1'b1;
        step();
        level_start = 1'b0;
    endtask

    task automatic measure_load(input string tag, input int exp_left);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        check({tag, "_busy_cycles"}, n, 16);
        check({tag, "_left"}, int'(diamonds_left), exp_left);
    endtask

    task automatic count_clear(input string tag, input int exp_draws);
        int nclr;
        int ndraw;
        int ncol;
        nclr = 0; ndraw = 0; ncol = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            nclr  += int'(level_clear);
            ndraw += int'(drawingRequest);
            ncol  += int'(collect_pulse);
        end
        check({tag, "_clear_pulses"}, nclr, 1);
        check({tag, "_draws"}, ndraw, exp_draws);
        check({tag, "_collects"}, ncol, 0);
    endtask

    initial begin
        vec_t vecs [13];
        int   left;

        vecs[0]  = '{11'd300, 11'd100, 1'b0, 1'b1, 1'b0, 21, "draw_3_9"};
        vecs[1]  = '{11'd700, 11'd100, 1'b0, 1'b0, 1'b0, 21, "col_out"};
        vecs[2]  = '{11'd10,  11'd10,  1'b0, 1'b0, 1'b0, 21, "empty_0_0"};
        vecs[3]  = '{11'd608, 11'd128, 1'b0, 1'b1, 1'b0, 21, "draw_4_19"};
        vecs[4]  = '{11'd608, 11'd480, 1'b0, 1'b0, 1'b0, 21, "row_out"};
        vecs[5]  = '{11'd288, 11'd96,  1'b1, 1'b1, 1'b1, 20, "hit_first"};
        vecs[6]  = '{11'd289, 11'd96,  1'b1, 1'b0, 1'b0, 20, "hit_again1"};
        vecs[7]  = '{11'd290, 11'd97,  1'b1, 1'b0, 1'b0, 20, "hit_again2"};
        vecs[8]  = '{11'd291, 11'd98,  1'b1, 1'b0, 1'b0, 20, "hit_again3"};
        vecs[9]  = '{11'd319, 11'd127, 1'b1, 1'b0, 1'b0, 20, "hit_again4"};
        vecs[10] = '{11'd300, 11'd100, 1'b0, 1'b0, 1'b0, 20, "gone_3_9"};
        vecs[11] = '{11'd10,  11'd10,  1'b1, 1'b0, 1'b0, 20, "hit_empty"};
        vecs[12] = '{11'd700, 11'd100, 1'b1, 1'b0, 1'b0, 20, "hit_out"};

        reset = 1'b1; level_start = 1'b0; level = 4'd0;
        pixelX = '0; pixelY = '0; collision = 1'b0;
        step();
        step();
        check("rst_draw", int'(drawingRequest), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_left", int'(diamonds_left), 0);
        check("rst_collect", int'(collect_pulse), 0);
        check("rst_clear", int'(level_clear), 0);
        reset = 1'b0;
        step();

        // Level 0 load
        start_level(4'd0);
        check("l0_busy_rise", int'(busy), 1);
        measure_load("l0", 21);

        // Lookup and single-count collection
        foreach (vecs[i]) begin
            pixelX    = vecs[i].x;
            pixelY    = vecs[i].y;
            collision = vecs[i].col;
            step();
            check({vecs[i].name, "_draw"}, int'(drawingRequest), int'(vecs[i].exp_draw));
            check({vecs[i].name, "_collect"}, int'(collect_pulse), int'(vecs[i].exp_collect));
            check({vecs[i].name, "_left"}, int'(diamonds_left), vecs[i].exp_left);
            check({vecs[i].name, "_lclr"}, int'(level_clear), 0);
        end
        collision = 1'b0;

        // Collect the remaining level-0 diamonds
        left = 20;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                if (map0[r][c] && !(r == 3 && c == 9)) begin
                    pixelX    = 11'(c * 32 + 7);
                    pixelY    = 11'(r * 32 + 7);
                    collision = 1'b1;
                    step();
                    left--;
                    check($sformatf("take_%0d_%0d_collect", r, c), int'(collect_pulse), 1);
                    check($sformatf("take_%0d_%0d_left", r, c), int'(diamonds_left), left);
                    collision = 1'b0;
                end
            end
        end
        count_clear("l0_end", 0);
        check("l0_end_busy", int'(busy), 0);

        // Out-of-range level: empty grid, immediate clear, collisions ignored
        start_level(4'd9);
        measure_load("l9", 0);
        pixelX = 11'd300; pixelY = 11'd100; collision = 1'b1;
        count_clear("l9_end", 0);
        check("l9_left_after", int'(diamonds_left), 0);
        collision = 1'b0;

        // Restart mid-load with level 4
        start_level(4'd0);
        for (int i = 0; i < 7; i++) step();
        start_level(4'd4);
        measure_load("l4", 130);
        pixelX = 11'd10; pixelY = 11'd10;
        step();
        check("l4_draw_0_0", int'(drawingRequest), 1);
        check("l4_lclr", int'(level_clear), 0);

        // Reset in RUN with a collision pending
        collision = 1'b1;
        reset     = 1'b1;
        step();
        check("rrun_draw", int'(drawingRequest), 0);
        check("rrun_busy", int'(busy), 0);
        check("rrun_left", int'(diamonds_left), 0);
        check("rrun_collect", int'(collect_pulse), 0);
        check("rrun_clear", int'(level_clear), 0);
        reset = 1'b0;
        step();
        check("post_rst_draw", int'(drawingRequest), 0);
        check("post_rst_collect", int'(collect_pulse), 0);
        collision = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
